// File: rtl/alu_issue.sv
// ============================================================================
// Module   : alu_issue
// Brief    : Sequences one ALU instruction at a time. It reads the operands
//            through a synchronous RF port, drives the ALU, and writes back
//            the result and flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [4:0]    i_op,
    input  logic [AW-1:0] i_rd,
    input  logic [AW-1:0] i_ra,
    input  logic [AW-1:0] i_rb,
    input  logic          i_imm_sel,
    input  logic [DW-1:0] i_imm,
    input  logic          i_nowb,
    output logic [AW-1:0] o_rf_raddr,
    input  logic [DW-1:0] i_rf_rdata,
    output logic          o_rf_we,
    output logic [AW-1:0] o_rf_waddr,
    output logic [DW-1:0] o_rf_wdata,
    output logic [4:0]    o_alu_op,
    output logic [DW-1:0] o_alu_a,
    output logic [DW-1:0] o_alu_b,
    input  logic [DW-1:0] i_alu_out,
    input  logic [7:0]    i_alu_flags,
    output logic [7:0]    o_flags,
    output logic          o_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_OPB  = 3'd3,
        S_EXEC = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t        r_state_q,   r_state_d;
    logic [4:0]    r_op_q,      r_op_d;
    logic [AW-1:0] r_rd_q,      r_rd_d;
    logic [AW-1:0] r_rb_q,      r_rb_d;
    logic          r_imm_sel_q, r_imm_sel_d;
    logic [DW-1:0] r_imm_q,     r_imm_d;
    logic          r_nowb_q,    r_nowb_d;
    logic [DW-1:0] r_a_q,       r_a_d;
    logic [AW-1:0] r_raddr_q,   r_raddr_d;
    logic [4:0]    r_alu_op_q,  r_alu_op_d;
    logic [DW-1:0] r_alu_a_q,   r_alu_a_d;
    logic [DW-1:0] r_alu_b_q,   r_alu_b_d;
    logic [AW-1:0] r_waddr_q,   r_waddr_d;
    logic [DW-1:0] r_wdata_q,   r_wdata_d;
    logic [7:0]    r_flg_q,     r_flg_d;
    logic [7:0]    r_flags_q,   r_flags_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q   <= S_IDLE;
            r_op_q      <= '0;
            r_rd_q      <= '0;
            r_rb_q      <= '0;
            r_imm_sel_q <= 1'b0;
            r_imm_q     <= '0;
            r_nowb_q    <= 1'b0;
            r_a_q       <= '0;
            r_raddr_q   <= '0;
            r_alu_op_q  <= '0;
            r_alu_a_q   <= '0;
            r_alu_b_q   <= '0;
            r_waddr_q   <= '0;
            r_wdata_q   <= '0;
            r_flg_q     <= '0;
            r_flags_q   <= '0;
        end else begin
            r_state_q   <= r_state_d;
            r_op_q      <= r_op_d;
            r_rd_q      <= r_rd_d;
            r_rb_q      <= r_rb_d;
            r_imm_sel_q <= r_imm_sel_d;
            r_imm_q     <= r_imm_d;
            r_nowb_q    <= r_nowb_d;
            r_a_q       <= r_a_d;
            r_raddr_q   <= r_raddr_d;
            r_alu_op_q  <= r_alu_op_d;
            r_alu_a_q   <= r_alu_a_d;
            r_alu_b_q   <= r_alu_b_d;
            r_waddr_q   <= r_waddr_d;
            r_wdata_q   <= r_wdata_d;
            r_flg_q     <= r_flg_d;
            r_flags_q   <= r_flags_d;
        end
    end

    // The read address is registered one state early so the synchronous RF
    // returns operand A in RDB and operand B in OPB.
    always_comb begin
        r_state_d   = r_state_q;
        r_op_d      = r_op_q;
        r_rd_d      = r_rd_q;
        r_rb_d      = r_rb_q;
        r_imm_sel_d = r_imm_sel_q;
        r_imm_d     = r_imm_q;
        r_nowb_d    = r_nowb_q;
        r_a_d       = r_a_q;
        r_raddr_d   = r_raddr_q;
        r_alu_op_d  = r_alu_op_q;
        r_alu_a_d   = r_alu_a_q;
        r_alu_b_d   = r_alu_b_q;
        r_waddr_d   = r_waddr_q;
        r_wdata_d   = r_wdata_q;
        r_flg_d     = r_flg_q;
        r_flags_d   = r_flags_q;

        case (r_state_q)
            S_IDLE: begin
                if (i_valid) begin
                    r_op_d      = i_op;
                    r_rd_d      = i_rd;
                    r_rb_d      = i_rb;
                    r_imm_sel_d = i_imm_sel;
                    r_imm_d     = i_imm;
                    r_nowb_d    = i_nowb;
                    r_raddr_d   = i_ra;
                    r_state_d   = S_RDA;
                end
            end
            S_RDA: begin
                if (!r_imm_sel_q) begin
                    r_raddr_d = r_rb_q;
                end
                r_state_d = S_RDB;
            end
            S_RDB: begin
                r_a_d = i_rf_rdata;
                if (r_imm_sel_q) begin
                    r_alu_op_d = r_op_q;
                    r_alu_a_d  = i_rf_rdata;
                    r_alu_b_d  = r_imm_q;
                    r_state_d  = S_EXEC;
                end else begin
                    r_state_d = S_OPB;
                end
            end
            S_OPB: begin
                r_alu_op_d = r_op_q;
                r_alu_a_d  = r_a_q;
                r_alu_b_d  = i_rf_rdata;
                r_state_d  = S_EXEC;
            end
            S_EXEC: begin
                r_waddr_d = r_rd_q;
                r_wdata_d = i_alu_out;
                r_flg_d   = i_alu_flags;
                r_state_d = S_WB;
            end
            S_WB: begin
                r_flags_d = r_flg_q;
                r_state_d = S_IDLE;
            end
            default: r_state_d = S_IDLE;
        endcase
    end

    assign o_ready    = (r_state_q == S_IDLE);
    assign o_done     = (r_state_q == S_WB);
    assign o_rf_we    = (r_state_q == S_WB) && !r_nowb_q && (r_rd_q != '0);
    assign o_rf_raddr = r_raddr_q;
    assign o_rf_waddr = r_waddr_q;
    assign o_rf_wdata = r_wdata_q;
    assign o_alu_op   = r_alu_op_q;
    assign o_alu_a    = r_alu_a_q;
    assign o_alu_b    = r_alu_b_q;
    assign o_flags    = r_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Directed bench for alu_issue with an RF/ALU model and a
//            write-back scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [4:0]    op;
    logic [AW-1:0] rd, ra, rb;
    logic          imm_sel;
    logic [DW-1:0] imm;
    logic          nowb;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [4:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b;
    logic [DW-1:0] alu_out;
    logic [7:0]    alu_flags;
    logic [7:0]    flags;
    logic          done;

    logic          tb_we;
    logic [AW-1:0] tb_waddr;
    logic [DW-1:0] tb_wdata;
    logic [DW-1:0] rf [2**AW];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [7:0]    flags;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue #(.AW(AW), .DW(DW)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_op        (op),
        .i_rd        (rd),
        .i_ra        (ra),
        .i_rb        (rb),
        .i_imm_sel   (imm_sel),
        .i_imm       (imm),
        .i_nowb      (nowb),
        .o_rf_raddr  (rf_raddr),
        .i_rf_rdata  (rf_rdata),
        .o_rf_we     (rf_we),
        .o_rf_waddr  (rf_waddr),
        .o_rf_wdata  (rf_wdata),
        .o_alu_op    (alu_op),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .i_alu_out   (alu_out),
        .i_alu_flags (alu_flags),
        .o_flags     (flags),
        .o_done      (done)
    );

    function automatic logic [DW-1:0] alu_res(input logic [4:0] f_op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (f_op)
            5'd0:    return a - b;
            5'd1:    return a & b;
            5'd2:    return a + b;
            5'd3:    return a ^ b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Synchronous-read register file and combinational ALU (bit 0 = zero flag)
    always @(posedge clk) begin
        rf_rdata <= rf[rf_raddr];
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (tb_we) rf[tb_waddr] <= tb_wdata;
    end

    always_comb begin
        alu_out   = alu_res(alu_op, alu_a, alu_b);
        alu_flags = {7'b0, (alu_out == '0)};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every o_done pops one expectation; flags checked a cycle later
    logic       pend = 1'b0;
    logic [7:0] pend_flags;
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            chk("flags_after_wb", flags, pend_flags);
            pend = 1'b0;
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                e = sb.pop_front();
                chk("wb_we", rf_we, e.we);
                if (e.we) begin
                    chk("wb_waddr", rf_waddr, e.waddr);
                    chk("wb_wdata", rf_wdata, e.wdata);
                end
                pend       = 1'b1;
                pend_flags = e.flags;
            end
        end
    end

    task automatic rf_poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic issue(input logic [4:0] t_op, input logic [AW-1:0] t_rd,
                         input logic [AW-1:0] t_ra, input logic [AW-1:0] t_rb,
                         input logic t_imm_sel, input logic [DW-1:0] t_imm,
                         input logic t_nowb, input logic push);
        exp_t e;
        logic [DW-1:0] b;
        valid = 1'b1; op = t_op; rd = t_rd; ra = t_ra; rb = t_rb;
        imm_sel = t_imm_sel; imm = t_imm; nowb = t_nowb;
        if (push) begin
            b       = t_imm_sel ? t_imm : rf[t_rb];
            e.wdata = alu_res(t_op, rf[t_ra], b);
            e.flags = {7'b0, (e.wdata == '0)};
            e.we    = !t_nowb && (t_rd != '0);
            e.waddr = t_rd;
            sb.push_back(e);
        end
    endtask

    task automatic garbage();
        valid = 1'b1; op = 5'($urandom); rd = AW'($urandom); ra = AW'($urandom);
        rb = AW'($urandom); imm_sel = 1'($urandom); imm = $urandom; nowb = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; op = '0; rd = '0; ra = '0; rb = '0;
        imm_sel = 1'b0; imm = '0; nowb = 1'b0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_raddr", rf_raddr, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_ready", ready, 1);
            chk("idle_flags", flags, 0);
            chk("idle_we", rf_we, 0);
            chk("idle_done", done, 0);
        end

        // Register form ADD: r4 = r1 + r2
        rf_poke(1, 5);
        rf_poke(2, 3);
        chk("add_ready_T", ready, 1);
        issue(5'd2, 4, 1, 2, 1'b0, '0, 1'b0, 1'b1);
        @(negedge clk); valid = 1'b0;
        chk("add_raddr_T1", rf_raddr, 1);
        chk("add_busy_T1", ready, 0);
        @(negedge clk);
        chk("add_raddr_T2", rf_raddr, 2);
        @(negedge clk);
        chk("add_done_T3", done, 0);
        @(negedge clk);
        chk("add_alu_op_T4", alu_op, 2);
        chk("add_alu_a_T4", alu_a, 5);
        chk("add_alu_b_T4", alu_b, 3);
        chk("add_done_T4", done, 0);
        @(negedge clk);
        chk("add_done_T5", done, 1);
        chk("add_we_T5", rf_we, 1);
        chk("add_waddr_T5", rf_waddr, 4);
        chk("add_wdata_T5", rf_wdata, 8);
        chk("add_alu_a_hold", alu_a, 5);
        @(negedge clk);
        chk("add_ready_T6", ready, 1);
        chk("add_done_T6", done, 0);
        chk("add_we_T6", rf_we, 0);

        // Immediate AND: rb=2 supplied but must never be read
        rf_poke(1, 32'h0F);
        issue(5'd1, 3, 1, 2, 1'b1, 32'h3C, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) valid = 1'b0;
            chk("imm_no_rb_read", rf_raddr == 2, 0);
            chk("imm_done", done, (k == 4));
        end
        chk("imm_wdata", rf_wdata, 32'h0C);
        @(negedge clk);
        chk("imm_ready_T5", ready, 1);

        // Flags-only compare, then rd=0 write suppression
        rf_poke(1, 7);
        rf_poke(2, 7);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) issue(5'd0, 5, 1, 2, 1'b0, '0, 1'b1, 1'b1);
            else           issue(5'd0, 0, 1, 2, 1'b0, '0, 1'b0, 1'b1);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (k == 1) valid = 1'b0;
                chk("cmp_no_we", rf_we, 0);
                chk("cmp_done", done, (k == 5));
            end
            @(negedge clk);
            chk("cmp_flags_T6", flags, 8'h01);
        end

        // Reset during EXEC, with an ALU-undefined op code in flight
        issue(5'h1F, 8, 1, 2, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) valid = 1'b0;
        end
        chk("rst_exec_op_pass", alu_op, 5'h1F);
        chk("rst_exec_flags_before", flags, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_exec_ready", ready, 1);
        chk("rst_exec_flags", flags, 0);
        for (int k = 0; k < 4; k++) begin
            chk("rst_exec_no_we", rf_we, 0);
            chk("rst_exec_no_done", done, 0);
            @(negedge clk);
        end

        // Busy-period inputs ignored; next accept happens in first IDLE cycle
        issue(5'd2, 6, 1, 2, 1'b0, '0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            garbage();
            chk("busy_not_ready", ready, 0);
        end
        @(negedge clk);
        chk("busy_ready_again", ready, 1);
        issue(5'd3, 7, 2, 6, 1'b0, '0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 5) valid = 1'b0;
            else garbage();
            chk("second_done", done, (k == 5));
        end
        chk("second_wdata", rf_wdata, 32'h9);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("final_ready", ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
